// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one-hot combinational grant, registered broadcast.
// Optional per-FU grant and stall counters are built when CDB_PERF_EN is defined.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     cdb_stall,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [2:0]               cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [NUM_FU*16-1:0]     perf_grants,
  output logic [15:0]              perf_stall_cycles
`endif
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] grant_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic              xfer_s;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [2:0]        cdb_src_q;

  // Round-robin scan starting at rr_ptr_q; flush, stall and reset suppress every grant.
  always_comb begin
    logic       found_v;
    int         sum_v;
    logic [PTR_W-1:0] idx_v;
    grant_s     = '0;
    grant_idx_s = '0;
    found_v     = 1'b0;
    sum_v       = 0;
    idx_v       = '0;
    if (rstn && !flush && !cdb_stall) begin
      for (int k = 0; k < NUM_FU; k++) begin
        sum_v = int'(rr_ptr_q) + k;
        if (sum_v >= NUM_FU) begin
          sum_v = sum_v - NUM_FU;
        end else begin
          sum_v = sum_v;
        end
        idx_v = PTR_W'(sum_v);
        if (!found_v && fu_valid[idx_v]) begin
          grant_s[idx_v] = 1'b1;
          grant_idx_s    = idx_v;
          found_v        = 1'b1;
        end else begin
          found_v = found_v;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  assign xfer_s = |(fu_valid & grant_s);

  // Pointer advances past the winner, wrapping at the last FU.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_s) begin
      if (int'(grant_idx_s) == NUM_FU - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Broadcast register: valid pulses per transfer, payload holds between transfers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 3'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= xfer_s && !flush;
      if (xfer_s) begin
        cdb_tag_q  <= fu_tag[grant_idx_s*TAG_W +: TAG_W];
        cdb_data_q <= fu_data[grant_idx_s*DATA_W +: DATA_W];
        cdb_src_q  <= 3'(grant_idx_s);
      end
    end
  end

  assign fu_ready  = grant_s;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_EN
  logic [NUM_FU*16-1:0] perf_grants_q;
  logic [15:0]          perf_stall_q;

  // Saturating counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_grants_q <= '0;
      perf_stall_q  <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && grant_s[i] && (perf_grants_q[i*16 +: 16] != 16'hFFFF)) begin
          perf_grants_q[i*16 +: 16] <= perf_grants_q[i*16 +: 16] + 16'd1;
        end
      end
      if (cdb_stall && (|fu_valid) && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_grants       = perf_grants_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
